// File: rtl/vga_pkg.sv
// Shared VGA-side definitions: VRAM geometry defaults, readout slot width,
// display slot reservation mask and the arbiter state encoding.
package vga_pkg;

   localparam int ADDR_W_DEF = 13;
   localparam int DATA_W_DEF = 8;
   localparam int CNT_W      = 3;
   localparam logic [7:0] DISP_SLOT_MASK_DEF = 8'b00000011;

   typedef enum logic {
      IDLE    = 1'b0,
      RD_WAIT = 1'b1
   } arb_state_e;

   // True when the display owns the current character-cell slot.
   function automatic logic disp_slot(input logic active, input logic [7:0] mask,
                                      input logic [CNT_W-1:0] cnt);
      return active && mask[cnt];
   endfunction

endpackage

// File: rtl/req_fifo.sv
// Synchronous in-order request queue; head entry is visible combinationally
// on rdata whenever the queue is non-empty.
module req_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 22
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             wdata,
   input  logic                     pop,
   output logic [W-1:0]             rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [W-1:0]     mem_q [DEPTH];
   logic [W-1:0]     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign full  = (count_q == (PTR_W+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/vram_arbiter.sv
// Schedules queued host VRAM accesses around display readout: writes go out at
// once, reads only in slots the display does not own.
module vram_arbiter
   import vga_pkg::*;
#(
   parameter int         DEPTH          = 4,
   parameter logic [7:0] DISP_SLOT_MASK = DISP_SLOT_MASK_DEF,
   parameter int         ADDR_W         = ADDR_W_DEF,
   parameter int         DATA_W         = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              active,
   input  logic [2:0]        readoutCount,
   input  logic [ADDR_W-1:0] readoutAddr,
   input  logic              reqValid,
   output logic              reqReady,
   input  logic              reqWe,
   input  logic [ADDR_W-1:0] reqAddr,
   input  logic [DATA_W-1:0] reqData,
   output logic              rdValid,
   output logic [DATA_W-1:0] rdData,
   output logic [ADDR_W-1:0] vramRdAddr,
   input  logic [DATA_W-1:0] vramRdData,
   output logic [ADDR_W-1:0] vramWrAddr,
   output logic [DATA_W-1:0] vramWrData,
   output logic              vramWr,
   output logic              busy
);

   localparam int ENT_W = 1 + ADDR_W + DATA_W;
   localparam int CNT_B = $clog2(DEPTH) + 1;

   logic              push, pop, full, empty;
   logic [CNT_B-1:0]  count, cnt_next;
   logic [ENT_W-1:0]  head;
   logic              head_we;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;

   arb_state_e        state_q, state_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              req_ready_q, req_ready_d;
   logic [ADDR_W-1:0] rd_addr;

   assign push = reqValid && req_ready_q && !full;
   assign {head_we, head_addr, head_data} = head;

   req_fifo #(.DEPTH(DEPTH), .W(ENT_W)) u_req_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata ({reqWe, reqAddr, reqData}),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   always_comb begin
      state_d    = state_q;
      pop        = 1'b0;
      wr_d       = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;
      rd_addr    = readoutAddr;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               if (head_we) begin
                  pop       = 1'b1;
                  wr_d      = 1'b1;
                  wr_addr_d = head_addr;
                  wr_data_d = head_data;
               // A read waits out the cycle its predecessor write is strobed,
               // so it always sees that write's data.
               end else if (!disp_slot(active, DISP_SLOT_MASK, readoutCount) && !wr_q) begin
                  pop     = 1'b1;
                  rd_addr = head_addr;
                  state_d = RD_WAIT;
               end
            end
         end
         RD_WAIT: begin
            rd_valid_d = 1'b1;
            rd_data_d  = vramRdData;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
      cnt_next = count + CNT_B'(push) - CNT_B'(pop);
      req_ready_d = (cnt_next != CNT_B'(DEPTH));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         wr_q        <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
         req_ready_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         wr_q        <= wr_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         rd_valid_q  <= rd_valid_d;
         rd_data_q   <= rd_data_d;
         req_ready_q <= req_ready_d;
      end
   end

   assign reqReady   = req_ready_q;
   assign rdValid    = rd_valid_q;
   assign rdData     = rd_data_q;
   assign vramRdAddr = rd_addr;
   assign vramWr     = wr_q;
   assign vramWrAddr = wr_addr_q;
   assign vramWrData = wr_data_q;
   assign busy       = (count != '0) || (state_q == RD_WAIT);

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus randomized traffic checked
// against a program-order memory model with expected write/read queues.
module tb_vram_arbiter;

   localparam logic [7:0] MASK = 8'b00000011;

   logic        clk = 1'b0;
   logic        rst;
   logic        active;
   logic [2:0]  readoutCount;
   logic [12:0] readoutAddr;
   logic        reqValid;
   logic        reqReady;
   logic        reqWe;
   logic [12:0] reqAddr;
   logic [7:0]  reqData;
   logic        rdValid;
   logic [7:0]  rdData;
   logic [12:0] vramRdAddr;
   logic [7:0]  vramRdData;
   logic [12:0] vramWrAddr;
   logic [7:0]  vramWrData;
   logic        vramWr;
   logic        busy;

   vram_arbiter dut (
      .clk(clk), .rst(rst), .active(active), .readoutCount(readoutCount),
      .readoutAddr(readoutAddr), .reqValid(reqValid), .reqReady(reqReady),
      .reqWe(reqWe), .reqAddr(reqAddr), .reqData(reqData), .rdValid(rdValid),
      .rdData(rdData), .vramRdAddr(vramRdAddr), .vramRdData(vramRdData),
      .vramWrAddr(vramWrAddr), .vramWrData(vramWrData), .vramWr(vramWr), .busy(busy)
   );

   always #5 clk = ~clk;

   // VRAM model: registered read, read-before-write on a shared edge.
   logic [7:0] vram   [8192];
   logic [7:0] shadow [8192];
   always @(posedge clk) begin
      if (vramWr) vram[vramWrAddr] <= vramWrData;
      vramRdData <= vram[vramRdAddr];
   end

   int n_checks = 0;
   int n_fail   = 0;
   int n_wr     = 0;
   int n_rd     = 0;
   bit rand_disp = 1'b0;
   logic [7:0]  last_rd;
   logic [7:0]  exp_q[$];
   logic [20:0] wexp_q[$];
   logic [7:0]  rd_log[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Output monitor: slot protection, write stream and read stream.
   always @(negedge clk) begin
      if (!rst) begin
         if (active && MASK[readoutCount]) check("slot_addr", vramRdAddr, readoutAddr);
         if (vramWr) begin
            n_wr++;
            if (wexp_q.size() == 0) check("wr_extra", 1, 0);
            else begin
               logic [20:0] w;
               w = wexp_q.pop_front();
               check("wr_addr", vramWrAddr, w[20:8]);
               check("wr_data", vramWrData, w[7:0]);
            end
         end
         if (rdValid) begin
            n_rd++;
            last_rd = rdData;
            rd_log.push_back(rdData);
            if (exp_q.size() == 0) check("rd_extra", 1, 0);
            else check("rd_data", rdData, exp_q.pop_front());
         end
      end
   end

   // Random display timing when enabled.
   initial forever begin
      @(posedge clk); #1;
      if (rand_disp) begin
         active       = 1'($urandom_range(0, 1));
         readoutCount = 3'($urandom_range(0, 7));
         readoutAddr  = 13'($urandom_range(0, 8191));
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      exp_q.delete();
      wexp_q.delete();
      step(); step();
      rst = 1'b0;
      for (int i = 0; i < 8192; i++) shadow[i] = vram[i];
   endtask

   // Present one request, hold until accepted, then record its effect in
   // program order.
   task automatic push_req(input logic we, input logic [12:0] addr, input logic [7:0] data);
      bit ok;
      ok = 1'b0;
      reqValid = 1'b1; reqWe = we; reqAddr = addr; reqData = data;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (reqReady) begin ok = 1'b1; break; end
         step();
      end
      step();
      reqValid = 1'b0;
      if (!ok) check("push_timeout", 1, 0);
      else if (we) begin
         shadow[addr] = data;
         wexp_q.push_back({addr, data});
      end else begin
         exp_q.push_back(shadow[addr]);
      end
   endtask

   task automatic wait_idle(input int max_cycles);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < max_cycles; i++) begin
         @(negedge clk); #1;
         if (!busy && !vramWr && !rdValid && exp_q.size() == 0 && wexp_q.size() == 0) begin
            ok = 1'b1; break;
         end
      end
      check("idle_reached", ok, 1);
      step();
   endtask

   initial begin
      int wr0, rd0;
      for (int i = 0; i < 8192; i++) vram[i] = 8'($urandom_range(0, 255));
      rst = 1'b1; active = 1'b0; readoutCount = 3'd0; readoutAddr = 13'h0123;
      reqValid = 1'b0; reqWe = 1'b0; reqAddr = '0; reqData = '0;
      do_reset();

      // Reset state
      @(negedge clk);
      check("rst_ready", reqReady, 1);
      check("rst_busy", busy, 0);
      check("rst_vramwr", vramWr, 0);
      check("rst_rdvalid", rdValid, 0);
      check("rst_rddata", rdData, 0);
      check("rst_wraddr", vramWrAddr, 0);
      check("rst_wrdata", vramWrData, 0);
      check("rst_rdaddr", vramRdAddr, 13'h0123);
      step();

      // Write then read, display inactive
      wr0 = n_wr; rd0 = n_rd;
      push_req(1'b1, 13'h05A0, 8'h3C);
      push_req(1'b0, 13'h05A0, 8'h00);
      wait_idle(50);
      check("wr_pulses", n_wr - wr0, 1);
      check("rd_pulses", n_rd - rd0, 1);
      check("wr_rd_value", last_rd, 8'h3C);

      // Slot blocking
      active = 1'b1; readoutCount = 3'd0; readoutAddr = 13'h1F00;
      push_req(1'b0, 13'h0010, 8'h00);
      @(negedge clk);
      check("blk0_addr", vramRdAddr, 13'h1F00);
      check("blk0_busy", busy, 1);
      step(); readoutCount = 3'd1;
      @(negedge clk);
      check("blk1_addr", vramRdAddr, 13'h1F00);
      step(); readoutCount = 3'd2;
      @(negedge clk);
      check("issue_addr", vramRdAddr, 13'h0010);
      step(); readoutCount = 3'd3;
      @(negedge clk);
      check("wait_addr", vramRdAddr, 13'h1F00);
      check("wait_rdvalid", rdValid, 0);
      step();
      @(negedge clk);
      check("slot_rdvalid", rdValid, 1);
      step();
      wait_idle(20);

      // Queue full
      active = 1'b1; readoutCount = 3'd0;
      rd0 = n_rd;
      for (int i = 0; i < 4; i++) push_req(1'b0, 13'(13'h0100 + i), 8'h00);
      @(negedge clk);
      check("full_ready", reqReady, 0);
      reqValid = 1'b1; reqWe = 1'b0; reqAddr = 13'h0104;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("full_hold", reqReady, 0);
         step();
      end
      reqValid = 1'b0;
      check("full_no_rd", n_rd - rd0, 0);
      readoutCount = 3'd2;
      wait_idle(60);
      check("full_drain", n_rd - rd0, 4);
      active = 1'b0;

      // Mixed ordering on one address
      rd_log.delete();
      push_req(1'b1, 13'h0001, 8'hAA);
      push_req(1'b0, 13'h0001, 8'h00);
      push_req(1'b1, 13'h0001, 8'hBB);
      push_req(1'b0, 13'h0001, 8'h00);
      wait_idle(50);
      check("mix_count", rd_log.size(), 2);
      if (rd_log.size() == 2) begin
         check("mix_first", rd_log[0], 8'hAA);
         check("mix_second", rd_log[1], 8'hBB);
      end

      // Reset during RD_WAIT
      rd0 = n_rd;
      push_req(1'b0, 13'h0200, 8'h00);
      step();
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("rdwait_busy", busy, 1);
      step();
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_rdvalid", rdValid, 0);
      check("post_rst_busy", busy, 0);
      check("post_rst_ready", reqReady, 1);
      for (int i = 0; i < 4; i++) step();
      check("post_rst_no_rd", n_rd - rd0, 0);
      for (int i = 0; i < 8192; i++) shadow[i] = vram[i];

      // Randomized traffic
      rand_disp = 1'b1;
      for (int n = 0; n < 200; n++) begin
         push_req(1'($urandom_range(0, 1)), 13'($urandom_range(0, 15)),
                  8'($urandom_range(0, 255)));
         repeat ($urandom_range(0, 2)) step();
      end
      wait_idle(1000);
      rand_disp = 1'b0;
      check("end_rd_q", exp_q.size(), 0);
      check("end_wr_q", wexp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
